// File: rtl/x2c_fifo_pkg.sv
// +--------------------------------------------------------------------+
// | x2c_fifo_pkg : default geometry and threshold constants for FIFO    |
// | Revision     : 1.0                                                  |
// +--------------------------------------------------------------------+
`default_nettype none

package x2c_fifo_pkg;

  localparam int c_WIDTH_DEF      = 256;
  localparam int c_PTR_DEF        = 10;
  localparam int c_DEPTH_DEF      = 1 << c_PTR_DEF;
  localparam int c_AFULL_GAP_DEF  = 8;
  localparam int c_AEMPTY_TH_DEF  = 8;

endpackage : x2c_fifo_pkg

`default_nettype wire

// File: rtl/x2c_sdp_ram.sv
// +--------------------------------------------------------------------+
// | x2c_sdp_ram : simple dual-port RAM, one write port, registered read |
// | Revision    : 1.0                                                   |
// +--------------------------------------------------------------------+
`default_nettype none

module x2c_sdp_ram
  import x2c_fifo_pkg::*;
#(
  parameter int WIDTH = c_WIDTH_DEF + 1,
  parameter int DEPTH = c_DEPTH_DEF,
  parameter int PTR   = c_PTR_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic [PTR-1:0]   waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [PTR-1:0]   raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Array kept reset-free so it maps onto block RAM; only the output register clears.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : x2c_sdp_ram

`default_nettype wire

// File: rtl/x2c_sync_fifo.sv
// +--------------------------------------------------------------------+
// | x2c_sync_fifo : single-clock FIFO with flags, packet count, and    |
// |                 optional FWFT read (define X2C_FIFO_FWFT_EN)        |
// | Revision      : 1.0                                                 |
// +--------------------------------------------------------------------+
`default_nettype none

module x2c_sync_fifo
  import x2c_fifo_pkg::*;
#(
  parameter int WIDTH     = c_WIDTH_DEF,
  parameter int DEPTH     = c_DEPTH_DEF,
  parameter int PTR       = c_PTR_DEF,
  parameter int AFULL_TH  = DEPTH - c_AFULL_GAP_DEF,
  parameter int AEMPTY_TH = c_AEMPTY_TH_DEF,
  parameter int PKT_MODE  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wrreq,
  input  logic [WIDTH-1:0] data,
  input  logic             wreop,
  output logic             full,
  output logic             afull,
  input  logic             rdreq,
  output logic [WIDTH-1:0] q,
  output logic             rdeop,
  output logic             empty,
  output logic             aempty,
  output logic [PTR:0]     usedw,
  output logic [PTR:0]     pkt_cnt,
  output logic             ovf,
  output logic             udf
);

  localparam logic [PTR:0] c_depth    = (PTR+1)'(DEPTH);
  localparam logic [PTR:0] c_afull    = (PTR+1)'(AFULL_TH);
  localparam logic [PTR:0] c_aempty   = (PTR+1)'(AEMPTY_TH);
  localparam logic [PTR:0] c_one      = (PTR+1)'(1);
  localparam logic         c_pkt_gate = (PKT_MODE != 0);

  logic [PTR-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR:0]   usedw_q, usedw_d, pkt_cnt_q, pkt_cnt_d;
  logic           ovf_q, ovf_d, udf_q, udf_d;
  logic           w_wr_acc, w_pop, w_rd_adv, w_head_eop, w_no_word;
  logic [WIDTH:0] w_ram_rdata;

  assign w_wr_acc = wrreq && !full;
  assign w_pop    = rdreq && !empty;

`ifdef X2C_FIFO_FWFT_EN
  logic valid_q, valid_d;
  logic w_fetch;

  // Prefetch whenever RAM holds unfetched words and the head slot is free or being popped.
  assign w_fetch    = (usedw_q > {{PTR{1'b0}}, valid_q}) && (!valid_q || w_pop);
  assign w_rd_adv   = w_fetch;
  assign w_head_eop = w_ram_rdata[WIDTH];
  assign w_no_word  = !valid_q;

  always_comb begin
    valid_d = valid_q;
    if (w_fetch) begin
      valid_d = 1'b1;
    end else if (w_pop) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end
`else
  logic [DEPTH-1:0] eop_tag_q;

  // The RAM copy of the tag arrives a cycle late; this shadow lets pkt_cnt drop on the pop itself.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      eop_tag_q[wr_ptr_q] <= wreop;
    end
  end

  assign w_rd_adv   = w_pop;
  assign w_head_eop = eop_tag_q[rd_ptr_q];
  assign w_no_word  = (usedw_q == '0);
`endif

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    usedw_d   = usedw_q;
    pkt_cnt_d = pkt_cnt_q;
    ovf_d     = ovf_q | (wrreq & full);
    udf_d     = udf_q | (rdreq & empty);
    if (w_wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR'(1);
    end
    if (w_rd_adv) begin
      rd_ptr_d = rd_ptr_q + PTR'(1);
    end
    if (w_wr_acc && !w_pop) begin
      usedw_d = usedw_q + c_one;
    end else if (!w_wr_acc && w_pop) begin
      usedw_d = usedw_q - c_one;
    end
    if ((w_wr_acc && wreop) && !(w_pop && w_head_eop)) begin
      pkt_cnt_d = pkt_cnt_q + c_one;
    end else if (!(w_wr_acc && wreop) && (w_pop && w_head_eop)) begin
      pkt_cnt_d = pkt_cnt_q - c_one;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      usedw_q   <= '0;
      pkt_cnt_q <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      usedw_q   <= usedw_d;
      pkt_cnt_q <= pkt_cnt_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  x2c_sdp_ram #(
    .WIDTH (WIDTH + 1),
    .DEPTH (DEPTH),
    .PTR   (PTR)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we_i    (w_wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i ({wreop, data}),
    .re_i    (w_rd_adv),
    .raddr_i (rd_ptr_q),
    .rdata_o (w_ram_rdata)
  );

  assign q       = w_ram_rdata[WIDTH-1:0];
  assign rdeop   = w_ram_rdata[WIDTH];
  assign usedw   = usedw_q;
  assign pkt_cnt = pkt_cnt_q;
  assign full    = (usedw_q == c_depth);
  assign afull   = (usedw_q >= c_afull);
  assign aempty  = (usedw_q <= c_aempty);
  assign empty   = w_no_word || (c_pkt_gate && (pkt_cnt_q == '0));
  assign ovf     = ovf_q;
  assign udf     = udf_q;

endmodule : x2c_sync_fifo

`default_nettype wire

// File: tb/tb_x2c_sync_fifo.sv
// +--------------------------------------------------------------------+
// | tb_x2c_sync_fifo : self-checking bench for x2c_sync_fifo            |
// | Revision         : 1.0                                              |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_x2c_sync_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       wrreq, wreop, rdreq;
  logic [7:0] data;
  logic       full, afull, empty, aempty, ovf, udf, rdeop;
  logic [7:0] q;
  logic [4:0] usedw, pkt_cnt;

  logic       wrreq1, wreop1, rdreq1;
  logic [7:0] data1;
  logic       full1, afull1, empty1, aempty1, ovf1, udf1, rdeop1;
  logic [7:0] q1;
  logic [4:0] usedw1, pkt_cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of {eop, data} plus sticky flags and last read word.
  logic [8:0] mq[$];
  logic [7:0] m_q;
  logic       m_eop, m_ovf, m_udf;

  x2c_sync_fifo #(
    .WIDTH(8), .DEPTH(16), .PTR(4), .AFULL_TH(14), .AEMPTY_TH(2), .PKT_MODE(0)
  ) dut0 (
    .clk(clk), .reset(reset), .wrreq(wrreq), .data(data), .wreop(wreop),
    .full(full), .afull(afull), .rdreq(rdreq), .q(q), .rdeop(rdeop),
    .empty(empty), .aempty(aempty), .usedw(usedw), .pkt_cnt(pkt_cnt),
    .ovf(ovf), .udf(udf)
  );

  x2c_sync_fifo #(
    .WIDTH(8), .DEPTH(16), .PTR(4), .AFULL_TH(14), .AEMPTY_TH(2), .PKT_MODE(1)
  ) dut1 (
    .clk(clk), .reset(reset), .wrreq(wrreq1), .data(data1), .wreop(wreop1),
    .full(full1), .afull(afull1), .rdreq(rdreq1), .q(q1), .rdeop(rdeop1),
    .empty(empty1), .aempty(aempty1), .usedw(usedw1), .pkt_cnt(pkt_cnt1),
    .ovf(ovf1), .udf(udf1)
  );

  function automatic logic [15:0] exp_vec();
    int n  = mq.size();
    int pk = 0;
    foreach (mq[i]) if (mq[i][8]) pk++;
    return {n == 16, n >= 14, n == 0, n <= 2, m_ovf, m_udf, 5'(n), 5'(pk)};
  endfunction

  function automatic logic [15:0] act_vec();
    return {full, afull, empty, aempty, ovf, udf, usedw, pkt_cnt};
  endfunction

  task automatic drive(input logic wr, input logic [7:0] d, input logic e, input logic rd);
    logic was_full, was_empty;
    wrreq = wr; data = d; wreop = e; rdreq = rd;
    was_full  = (mq.size() == 16);
    was_empty = (mq.size() == 0);
    @(posedge clk); #1;
    if (wr && was_full)  m_ovf = 1'b1;
    if (rd && was_empty) m_udf = 1'b1;
    if (rd && !was_empty) {m_eop, m_q} = mq.pop_front();
    if (wr && !was_full)  mq.push_back({e, d});
    wrreq = 1'b0; rdreq = 1'b0; wreop = 1'b0;
  endtask

  task automatic drive1(input logic wr, input logic [7:0] d, input logic e, input logic rd);
    wrreq1 = wr; data1 = d; wreop1 = e; rdreq1 = rd;
    @(posedge clk); #1;
    wrreq1 = 1'b0; rdreq1 = 1'b0; wreop1 = 1'b0;
  endtask

  task automatic model_clear();
    mq.delete();
    m_q = 8'h00; m_eop = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    reset = 1'b1; wrreq = 1'b1; rdreq = 1'b1; data = 8'h3C; wreop = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (act_vec() !== 16'h3000) begin
      n_fail++; $display("FAIL reset_flags: got %h expected %h", act_vec(), 16'h3000);
    end
    n_checks++;
    if ({rdeop, q} !== 9'h000) begin
      n_fail++; $display("FAIL reset_q: got %h expected %h", {rdeop, q}, 9'h000);
    end
    n_checks++;
    if ({empty1, usedw1, pkt_cnt1} !== 11'h400) begin
      n_fail++; $display("FAIL reset_pkt_dut: got %h expected %h", {empty1, usedw1, pkt_cnt1}, 11'h400);
    end
    wrreq = 1'b0; rdreq = 1'b0; wreop = 1'b0;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_underflow();
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    n_checks++;
    if ({udf, q, usedw} !== {1'b1, 8'h00, 5'd0}) begin
      n_fail++; $display("FAIL udf_set: got %h expected %h", {udf, q, usedw}, {1'b1, 8'h00, 5'd0});
    end
    n_checks++;
    if (act_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL udf_flags: got %h expected %h", act_vec(), exp_vec());
    end
    repeat (3) drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    n_checks++;
    if (udf !== 1'b1) begin
      n_fail++; $display("FAIL udf_sticky: got %b expected 1", udf);
    end
    do_reset();
    n_checks++;
    if (udf !== 1'b0) begin
      n_fail++; $display("FAIL udf_clear: got %b expected 0", udf);
    end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0);
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL fill_flags[%0d]: got %h expected %h", i, act_vec(), exp_vec());
      end
    end
    drive(1'b1, 8'hAA, 1'b0, 1'b0);
    n_checks++;
    if ({full, afull, usedw, ovf} !== {1'b1, 1'b1, 5'd16, 1'b1}) begin
      n_fail++; $display("FAIL ovf_full: got %h expected %h", {full, afull, usedw, ovf}, {1'b1, 1'b1, 5'd16, 1'b1});
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      n_checks++;
      if ({rdeop, q} !== {1'b0, 8'(i)}) begin
        n_fail++; $display("FAIL drain_q[%0d]: got %h expected %h", i, {rdeop, q}, {1'b0, 8'(i)});
      end
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL drain_flags[%0d]: got %h expected %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_both_requests();
    do_reset();
    for (int i = 0; i < 16; i++) drive(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    drive(1'b1, 8'h55, 1'b0, 1'b1);
    n_checks++;
    if ({usedw, q} !== {5'd15, 8'h20}) begin
      n_fail++; $display("FAIL both_full: got %h expected %h", {usedw, q}, {5'd15, 8'h20});
    end
    for (int i = 1; i < 16; i++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      n_checks++;
      if (q !== m_q) begin
        n_fail++; $display("FAIL both_drain_q[%0d]: got %h expected %h", i, q, m_q);
      end
    end
    drive(1'b1, 8'h77, 1'b0, 1'b1);
    n_checks++;
    if ({usedw, q} !== {5'd1, 8'h2F}) begin
      n_fail++; $display("FAIL both_empty: got %h expected %h", {usedw, q}, {5'd1, 8'h2F});
    end
    n_checks++;
    if (act_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL both_empty_flags: got %h expected %h", act_vec(), exp_vec());
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    n_checks++;
    if (q !== 8'h77) begin
      n_fail++; $display("FAIL both_late_word: got %h expected %h", q, 8'h77);
    end
  endtask

  task automatic test_pkt_mode();
    do_reset();
    for (int i = 0; i < 3; i++) drive1(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    n_checks++;
    if ({empty1, usedw1, pkt_cnt1} !== {1'b1, 5'd3, 5'd0}) begin
      n_fail++; $display("FAIL pkt_gated: got %h expected %h", {empty1, usedw1, pkt_cnt1}, {1'b1, 5'd3, 5'd0});
    end
    drive1(1'b0, 8'h00, 1'b0, 1'b1);
    n_checks++;
    if ({udf1, usedw1} !== {1'b1, 5'd3}) begin
      n_fail++; $display("FAIL pkt_gated_read: got %h expected %h", {udf1, usedw1}, {1'b1, 5'd3});
    end
    drive1(1'b1, 8'h43, 1'b1, 1'b0);
    n_checks++;
    if ({empty1, usedw1, pkt_cnt1} !== {1'b0, 5'd4, 5'd1}) begin
      n_fail++; $display("FAIL pkt_complete: got %h expected %h", {empty1, usedw1, pkt_cnt1}, {1'b0, 5'd4, 5'd1});
    end
    for (int i = 0; i < 4; i++) begin
      drive1(1'b0, 8'h00, 1'b0, 1'b1);
      n_checks++;
      if ({rdeop1, q1} !== {(i == 3), 8'(8'h40 + i)}) begin
        n_fail++; $display("FAIL pkt_read[%0d]: got %h expected %h", i, {rdeop1, q1}, {(i == 3), 8'(8'h40 + i)});
      end
    end
    n_checks++;
    if ({empty1, usedw1, pkt_cnt1} !== {1'b1, 5'd0, 5'd0}) begin
      n_fail++; $display("FAIL pkt_drained: got %h expected %h", {empty1, usedw1, pkt_cnt1}, {1'b1, 5'd0, 5'd0});
    end
  endtask

  task automatic test_random_wrap();
    logic wr, rd;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (((c / 40) % 2) == 0) begin
        wr = ($urandom_range(0, 3) != 0);
        rd = ($urandom_range(0, 3) == 0);
      end else begin
        wr = ($urandom_range(0, 3) == 0);
        rd = ($urandom_range(0, 3) != 0);
      end
      drive(wr, 8'($urandom), 1'($urandom), rd);
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL rand_flags[%0d]: got %h expected %h", c, act_vec(), exp_vec());
      end
      n_checks++;
      if ({rdeop, q} !== {m_eop, m_q}) begin
        n_fail++; $display("FAIL rand_q[%0d]: got %h expected %h", c, {rdeop, q}, {m_eop, m_q});
      end
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int i = 0; i < 9; i++) drive(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    n_checks++;
    if (usedw !== 5'd9) begin
      n_fail++; $display("FAIL mid_prefill: got %0d expected 9", usedw);
    end
    do_reset();
    n_checks++;
    if ({usedw, empty} !== {5'd0, 1'b1}) begin
      n_fail++; $display("FAIL mid_reset: got %h expected %h", {usedw, empty}, {5'd0, 1'b1});
    end
    drive(1'b1, 8'h99, 1'b1, 1'b0);
    n_checks++;
    if ({empty, usedw, pkt_cnt} !== {1'b0, 5'd1, 5'd1}) begin
      n_fail++; $display("FAIL mid_first_write: got %h expected %h", {empty, usedw, pkt_cnt}, {1'b0, 5'd1, 5'd1});
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    n_checks++;
    if ({rdeop, q} !== 9'h199) begin
      n_fail++; $display("FAIL mid_first_read: got %h expected %h", {rdeop, q}, 9'h199);
    end
  endtask

  initial begin
    reset = 1'b1;
    wrreq = 1'b0; rdreq = 1'b0; wreop = 1'b0; data = 8'h00;
    wrreq1 = 1'b0; rdreq1 = 1'b0; wreop1 = 1'b0; data1 = 8'h00;
    model_clear();
    test_reset();
    test_underflow();
    test_fill_overflow();
    test_both_requests();
    test_pkt_mode();
    test_random_wrap();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_x2c_sync_fifo

`default_nettype wire

// File: doc/x2c_sync_fifo.md
X2C_SYNC_FIFO -- requirements
Module: x2c_sync_fifo

Interface
REQ-001 SHALL have parameter WIDTH, 256, data word width.
REQ-002 SHALL have parameter DEPTH, 1024, entries; DEPTH SHALL equal 2**PTR.
REQ-003 SHALL have parameter PTR, 10, pointer width; count width PTR+1.
REQ-004 SHALL have parameter AFULL_TH, DEPTH-8, almost-full threshold.
REQ-005 SHALL have parameter AEMPTY_TH, 8, almost-empty threshold.
REQ-006 SHALL have parameter PKT_MODE, 0, 1 = store-and-forward packet gating.
REQ-007 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-008 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-009 SHALL have port wrreq  in  1  write request.
REQ-010 SHALL have port data  in  WIDTH  write data.
REQ-011 SHALL have port wreop  in  1  end-of-packet tag stored with data.
REQ-012 SHALL have port full  out  1  no free entry.
REQ-013 SHALL have port afull  out  1  usedw >= AFULL_TH.
REQ-014 SHALL have port rdreq  in  1  read request.
REQ-015 SHALL have port q  out  WIDTH  read data.
REQ-016 SHALL have port rdeop  out  1  eop tag of word on q.
REQ-017 SHALL have port empty  out  1  no readable word.
REQ-018 SHALL have port aempty  out  1  usedw <= AEMPTY_TH.
REQ-019 SHALL have port usedw  out  PTR+1  stored word count, 0..DEPTH.
REQ-020 SHALL have port pkt_cnt  out  PTR+1  complete packets stored.
REQ-021 SHALL have port ovf  out  1  sticky: write attempted while full.
REQ-022 SHALL have port udf  out  1  sticky: read attempted while empty.

Function
REQ-023 Write accepted iff wrreq && !full; {wreop,data} stored at wr pointer, pointer wraps DEPTH-1 -> 0.
REQ-024 Read accepted iff rdreq && !empty; rd pointer advances with same wrap.
REQ-025 usedw: +1 on write only, -1 on read only, unchanged on both; full = (usedw==DEPTH); all flags derived from registered usedw/pkt_cnt.
REQ-026 Full and both requests: read accepted, write rejected; empty and both: write accepted, read rejected.
REQ-027 Rejected write: storage unchanged, ovf set and held until reset; rejected read: q/rdeop hold, udf set and held.
REQ-028 pkt_cnt: +1 on accepted write with wreop=1, -1 on accepted read of word tagged eop, unchanged if both.
REQ-029 PKT_MODE=0: empty = (usedw==0); PKT_MODE=1: empty = (usedw==0) || (pkt_cnt==0); full/ovf unaffected by PKT_MODE.
REQ-030 Standard read: q/rdeop update exactly 1 cycle after accepted read and hold otherwise; empty falls cycle after first write into empty FIFO.
REQ-031 afull/aempty SHALL track usedw every cycle, no hysteresis.

Reset
REQ-032 reset has priority over wrreq/rdreq in same cycle; clears pointers, usedw=0, pkt_cnt=0, empty=1, aempty=1, full=0, afull=0, ovf=0, udf=0, q=0, rdeop=0; storage not cleared.
REQ-033 Reset mid-stream discards all content; first post-reset write behaves as write into empty FIFO.

Configuration
REQ-034 Macro X2C_FIFO_FWFT_EN defined: first-word-fall-through; q/rdeop show head word whenever empty=0, rdreq pops it, next word visible next cycle; empty falls 2 cycles after write into empty FIFO; usedw includes prefetched word.
REQ-035 Macro undefined: standard 1-cycle read latency per REQ-030; no prefetch register.

Structure
REQ-036 Package x2c_fifo_pkg SHALL hold default WIDTH/DEPTH/PTR constants and threshold defaults; flag/counter logic local.
REQ-037 Storage SHALL be sub-module x2c_sdp_ram, (WIDTH+1) x DEPTH simple dual-port, registered read.

Verification (bench: WIDTH=8, DEPTH=16, PTR=4, AFULL_TH=14, AEMPTY_TH=2)
REQ-038 Write 0x00..0x0F, 17th write 0xAA -> full=1, afull=1, usedw=16, ovf=1; reading 16 words returns 0x00..0x0F, 0xAA never seen.
REQ-039 rdreq with empty after reset -> udf=1, q=0x00, usedw=0; udf stays 1 until reset.
REQ-040 Full FIFO, wrreq+rdreq same cycle -> usedw 16->15, write dropped; empty, both -> usedw 0->1, q unchanged.
REQ-041 PKT_MODE=1: write 3 words, wreop=0 -> empty=1, usedw=3; 4th word wreop=1 -> pkt_cnt=1, empty=0; read 4 -> rdeop=1 on 4th, pkt_cnt=0.
REQ-042 Write 20, read 20 interleaved across wrap -> data in order, aempty toggles at usedw 2/3, afull at 13/14; reset asserted with usedw=9 -> next cycle usedw=0, empty=1.
